// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between fetch (IF) and data (DM) stages.
// One transaction in flight, fixed latency, DM priority with IF starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
  localparam logic [3:0] S_MAX  = 4'(STARVE_MAX);

  state_t            state;
  logic [3:0]        cnt;
  logic [3:0]        starve;
  logic              owner_dm;
  logic              owner_we;
  logic              killed;
  logic [DATA_W-1:0] if_q;
  logic [DATA_W-1:0] dm_q;

  logic if_cand;
  logic grant;
  logic pick_if;
  logic dm_win;

  // A flushed fetch does not compete for the port this cycle.
  assign if_cand = if_req & ~if_flush;
  assign grant   = ~rst & (state == IDLE) & (if_cand | dm_req);
  assign pick_if = if_cand & (~dm_req | (starve == S_MAX));
  assign dm_win  = grant & ~pick_if;

  assign mem_en    = grant;
  assign mem_we    = dm_win & dm_we;
  assign mem_addr  = !grant ? '0 : (pick_if ? if_addr : dm_addr);
  assign mem_wdata = dm_win ? dm_wdata : '0;

  assign if_done = ~rst & (state == DONE) & ~owner_dm
                 & ~killed & ~if_flush;
  assign dm_done = ~rst & (state == DONE) & owner_dm;

  assign if_rdata = if_done ? mem_rdata : if_q;
  assign dm_rdata = (dm_done & ~owner_we) ? mem_rdata : dm_q;

  assign stall_if  = ~rst & if_req & ~if_done;
  assign stall_mem = ~rst & dm_req & ~dm_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      starve   <= '0;
      owner_dm <= 1'b0;
      owner_we <= 1'b0;
      killed   <= 1'b0;
      if_q     <= '0;
      dm_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            owner_dm <= ~pick_if;
            owner_we <= dm_win & dm_we;
            killed   <= 1'b0;
            cnt      <= LAT_M1;
            state    <= (MEM_LAT == 1) ? DONE : BUSY;
          end
          if (grant && pick_if)
            starve <= '0;
          else if (!if_req)
            starve <= '0;
          else if (dm_win && if_cand && starve != S_MAX)
            starve <= starve + 4'd1;
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= DONE;
          if (!owner_dm && if_flush)
            killed <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          if (if_done)
            if_q <= mem_rdata;
          if (dm_done && !owner_we)
            dm_q <= mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed-latency memory model.
// Expected values are hand-computed for MEM_LAT=2, STARVE_MAX=3.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [9:0]  if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [9:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_done;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(
    .ADDR_W(10), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(3)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  // Memory: writes on the grant edge, read data appears two cycles later.
  logic [31:0] mem [0:1023];
  logic [9:0]  a1, a2;

  always @(posedge clk) begin
    if (rst) begin
      mem[6]  <= 32'hA000_0006;
      mem[7]  <= 32'hB000_0007;
      mem[12] <= 32'hC000_000C;
      mem[39] <= 32'd5;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    a1 <= mem_addr;
    a2 <= a1;
  end

  assign mem_rdata = mem[a2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [9:0] order [0:4];

  initial begin
    order[0] = 10'd39; order[1] = 10'd39; order[2] = 10'd39;
    order[3] = 10'd6;  order[4] = 10'd39;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    step();
    step();
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_dm_done", 32'(dm_done), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_stalls", 32'({stall_if, stall_mem}), 32'd0);

    // Reset in the middle of a load
    rst = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd39;
    #1;
    chk("mid_grant_en", 32'(mem_en), 32'd1);
    chk("mid_grant_addr", 32'(mem_addr), 32'd39);
    step();
    rst = 1'b1; dm_req = 1'b0;
    step();
    chk("mid_rst_no_done", 32'(dm_done), 32'd0);
    chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
    rst = 1'b0;
    step();
    chk("mid_idle_no_done", 32'(dm_done), 32'd0);
    chk("mid_idle_mem_en", 32'(mem_en), 32'd0);
    dm_req = 1'b1;
    #1;
    chk("re_grant_en", 32'(mem_en), 32'd1);
    step();
    chk("re_busy_done", 32'(dm_done), 32'd0);
    chk("re_busy_stall", 32'(stall_mem), 32'd1);
    step();
    chk("re_done", 32'(dm_done), 32'd1);
    chk("re_rdata", dm_rdata, 32'd5);
    chk("re_stall_clr", 32'(stall_mem), 32'd0);
    dm_req = 1'b0;
    step();

    // Single fetch
    if_req = 1'b1; if_addr = 10'd6;
    #1;
    chk("f_en", 32'(mem_en), 32'd1);
    chk("f_addr", 32'(mem_addr), 32'd6);
    chk("f_we", 32'(mem_we), 32'd0);
    chk("f_stall_t0", 32'(stall_if), 32'd1);
    step();
    chk("f_stall_t1", 32'(stall_if), 32'd1);
    chk("f_t1_done", 32'(if_done), 32'd0);
    chk("f_t1_en", 32'(mem_en), 32'd0);
    step();
    chk("f_done", 32'(if_done), 32'd1);
    chk("f_rdata", if_rdata, 32'hA000_0006);
    chk("f_stall_t2", 32'(stall_if), 32'd0);
    chk("f_t2_en", 32'(mem_en), 32'd0);
    if_req = 1'b0;
    step();
    chk("f_hold", if_rdata, 32'hA000_0006);
    chk("f_done_pulse", 32'(if_done), 32'd0);

    // Store then load
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd39; dm_wdata = 32'd20;
    #1;
    chk("sw_en", 32'(mem_en), 32'd1);
    chk("sw_we", 32'(mem_we), 32'd1);
    chk("sw_wdata", mem_wdata, 32'd20);
    step();
    step();
    chk("sw_done", 32'(dm_done), 32'd1);
    chk("sw_rdata_hold", dm_rdata, 32'd5);
    dm_we = 1'b0;
    step();
    chk("lw_en", 32'(mem_en), 32'd1);
    chk("lw_we", 32'(mem_we), 32'd0);
    chk("lw_addr", 32'(mem_addr), 32'd39);
    step();
    chk("lw_t4_done", 32'(dm_done), 32'd0);
    step();
    chk("lw_done", 32'(dm_done), 32'd1);
    chk("lw_rdata", dm_rdata, 32'd20);
    dm_req = 1'b0;
    step();

    // Contention: DM, DM, DM, IF, DM
    if_req = 1'b1; if_addr = 10'd6;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd39;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("arb_en_%0d", k), 32'(mem_en), 32'd1);
      chk($sformatf("arb_addr_%0d", k), 32'(mem_addr), 32'(order[k]));
      step();
      step();
      step();
    end

    // Flush in IDLE with both requests: DM wins, starvation count held at 1
    if_flush = 1'b1;
    #1;
    chk("iflush_en", 32'(mem_en), 32'd1);
    chk("iflush_addr", 32'(mem_addr), 32'd39);
    step();
    if_flush = 1'b0;
    step();
    step();
    chk("post_a", 32'(mem_addr), 32'd39);
    step();
    step();
    step();
    chk("post_b", 32'(mem_addr), 32'd39);
    step();
    step();
    step();
    chk("post_c", 32'(mem_addr), 32'd6);
    if_req = 1'b0; dm_req = 1'b0;
    step();
    step();
    step();

    // Flush of an in-flight fetch
    if_req = 1'b1; if_addr = 10'd7;
    #1;
    chk("fl_grant", 32'(mem_addr), 32'd7);
    step();
    if_flush = 1'b1;
    step();
    chk("fl_no_done", 32'(if_done), 32'd0);
    chk("fl_rdata_hold", if_rdata, 32'hA000_0006);
    if_flush = 1'b0; if_addr = 10'd12;
    step();
    chk("fl_regrant_en", 32'(mem_en), 32'd1);
    chk("fl_regrant_addr", 32'(mem_addr), 32'd12);
    step();
    step();
    chk("fl_new_done", 32'(if_done), 32'd1);
    chk("fl_new_rdata", if_rdata, 32'hC000_000C);
    if_req = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between the mips32 instruction-fetch stage (IF) and the data-memory stage (DM: LW/SW).
- Serializes accesses with one outstanding transaction at a time, a fixed memory latency, and fixed DM priority with an anti-starvation override for IF.
- Generates per-stage stall signals for the pipeline.
- Supports flushing an in-flight fetch on a taken branch or jump.

Parameters:
ADDR_W, 10, word address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from grant (mem_en) to mem_rdata valid; legal range 1..15
STARVE_MAX, 3, consecutive DM grants with IF waiting before IF is forced; 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request; held with if_addr until if_done
if_addr  in  ADDR_W  fetch word address
if_flush  in  1  discard pending or in-flight fetch
if_done  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  DATA_W  fetched instruction
dm_req  in  1  data request; held with dm_we/addr/wdata until dm_done
dm_we  in  1  1=SW, 0=LW
dm_addr  in  ADDR_W  data word address
dm_wdata  in  DATA_W  store data
dm_done  out  1  one-cycle pulse; LW data or SW completion
dm_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe, one cycle per transaction
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
stall_if  out  1  if_req & ~if_done
stall_mem  out  1  dm_req & ~dm_done

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset: state=IDLE. All outputs 0: done pulses, rdata, mem_* and stalls. Starvation counter=0 and owner cleared. Reset mid-transaction abandons it with no done pulse.
- IDLE, no request: stay in IDLE with mem_en=0.
- IDLE, any request: grant in the same cycle.
  - mem_en=1; mem_addr, mem_we and mem_wdata come from the winner. IF grants have mem_we=0.
  - Latch the owner. Load the latency counter with MEM_LAT-1. Go to BUSY.
- Arbitration:
  - Only DM requesting: DM wins. Only IF requesting: IF wins.
  - Both requesting: DM wins unless starve_cnt==STARVE_MAX, in which case IF wins.
  - starve_cnt increments on each DM grant while if_req=1 (saturating at STARVE_MAX). It clears on any IF grant and whenever if_req=0 in IDLE.
- BUSY: decrement the counter each cycle. When the counter reaches 0, go to DONE; this cycle is grant+MEM_LAT.
- DONE (one cycle):
  - Capture mem_rdata into the owner's rdata register and pulse the owner's done.
  - For SW, dm_done pulses and dm_rdata holds its previous value.
  - Next state is IDLE. Earliest next grant is grant+MEM_LAT+1, so throughput is one access per MEM_LAT+1 cycles.
- Requesters sample done on the DONE cycle and present the next request/address in the following IDLE cycle. A req still high in IDLE is a new request.
- if_flush:
  - If the owner is IF in BUSY or DONE, mark the transaction killed: if_done stays 0 for it and if_rdata is not updated. The memory read still completes, and the arbiter returns to IDLE on schedule.
  - If if_flush and if_req are both high in IDLE, IF is excluded from arbitration that cycle; DM may still be granted.
  - if_flush has no effect on DM transactions.
- rdata registers hold their value until the next own completion.
- stall_if and stall_mem are combinational from req and done.
- No address-range or alignment checking; addresses pass through unchanged.

Test Plan:
- Reset mid-BUSY:
  - MEM_LAT=2. dm_req=1, dm_we=0, dm_addr=39, mem[39]=5; assert rst the cycle after the grant.
  - Expect: no dm_done, mem_en=0, state IDLE.
  - Re-request after reset: dm_done at grant+2 with dm_rdata=5.
- Single fetch:
  - if_req=1, if_addr=6; grant at T.
  - Expect: mem_en=1 and mem_addr=6 at T; if_done=1 with if_rdata=mem[6] at T+2; stall_if=1 during T..T+1; next grant no earlier than T+3.
- Store then load:
  - SW: dm_we=1, addr=39, wdata=20, granted at T.
  - Expect: mem_we=1 at T, dm_done at T+2, dm_rdata unchanged.
  - Following LW of addr 39 is granted at T+3; dm_done at T+5 with dm_rdata=20.
- Contention with starvation (STARVE_MAX=3):
  - Hold if_req and dm_req continuously; DM re-requests after each done.
  - Expect grant order DM, DM, DM, IF, DM... with starve_cnt 1,2,3,0.
- Fetch flush:
  - IF granted at T; if_flush=1 at T+1.
  - Expect: no if_done at T+2, if_rdata unchanged, IDLE at T+3.
  - A new if_addr=12 presented at T+3 is granted at T+3.
- Simultaneous flush in IDLE:
  - if_req=1, if_flush=1, dm_req=1 in the same IDLE cycle.
  - Expect: DM granted, starve_cnt unchanged, IF not granted that cycle.
